// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and the MEM stage.
// Data wins ties because it belongs to the older instruction; a granted transaction is never preempted.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  InstrReq,
    input  logic [ADDR_WIDTH-1:0] InstrAddr,
    input  logic                  DataReq,
    input  logic                  DataWE,
    input  logic [ADDR_WIDTH-1:0] DataAddr,
    input  logic [DATA_WIDTH-1:0] DataWD,
    input  logic [3:0]            DataBE,
    output logic                  MemReq,
    output logic                  MemWE,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWD,
    output logic [3:0]            MemBE,
    input  logic                  MemReady,
    input  logic [DATA_WIDTH-1:0] MemRD,
    output logic                  InstrValid,
    output logic [DATA_WIDTH-1:0] InstrRD,
    output logic                  DataValid,
    output logic [DATA_WIDTH-1:0] DataRD,
    output logic                  StallFetchReq,
    output logic                  StallMemReq,
    output logic                  TimeoutErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);

    state_t                  stateReg, stateNext;
    logic [7:0]              waitCnt, waitCntNext, waitInc;
    logic                    memReqNext, memWENext;
    logic [ADDR_WIDTH-1:0]   memAddrNext;
    logic [DATA_WIDTH-1:0]   memWDNext;
    logic [3:0]              memBENext;
    logic                    instrValidNext, dataValidNext;
    logic [DATA_WIDTH-1:0]   instrRDNext, dataRDNext;
    logic                    timeoutErrNext;

    // Saturating increment so a stuck memory cannot wrap the counter back under the limit.
    assign waitInc = (waitCnt == 8'hFF) ? waitCnt : waitCnt + 8'd1;

    always_comb begin
        stateNext      = stateReg;
        waitCntNext    = waitCnt;
        memReqNext     = MemReq;
        memWENext      = MemWE;
        memAddrNext    = MemAddr;
        memWDNext      = MemWD;
        memBENext      = MemBE;
        instrValidNext = 1'b0;
        dataValidNext  = 1'b0;
        instrRDNext    = InstrRD;
        dataRDNext     = DataRD;
        timeoutErrNext = TimeoutErr;

        case (stateReg)
            IDLE: begin
                if (DataReq) begin
                    memReqNext  = 1'b1;
                    memWENext   = DataWE;
                    memAddrNext = DataAddr;
                    memWDNext   = DataWD;
                    memBENext   = DataBE;
                    waitCntNext = 8'd0;
                    stateNext   = DATA;
                end else if (InstrReq) begin
                    memReqNext  = 1'b1;
                    memWENext   = 1'b0;
                    memAddrNext = InstrAddr;
                    memBENext   = 4'b1111;
                    waitCntNext = 8'd0;
                    stateNext   = INSTR;
                end
            end
            INSTR, DATA: begin
                if (MemReady) begin
                    memReqNext = 1'b0;
                    stateNext  = IDLE;
                    if (stateReg == INSTR) begin
                        instrRDNext    = MemRD;
                        instrValidNext = 1'b1;
                    end else begin
                        if (!MemWE) begin
                            dataRDNext = MemRD;
                        end
                        dataValidNext = 1'b1;
                    end
                end else begin
                    waitCntNext = waitInc;
                    if (waitInc >= TimeoutLimit) begin
                        timeoutErrNext = 1'b1;
                    end
                end
            end
            default: begin
                memReqNext = 1'b0;
                stateNext  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg   <= IDLE;
            waitCnt    <= 8'd0;
            MemReq     <= 1'b0;
            MemWE      <= 1'b0;
            MemAddr    <= '0;
            MemWD      <= '0;
            MemBE      <= 4'b0000;
            InstrValid <= 1'b0;
            InstrRD    <= '0;
            DataValid  <= 1'b0;
            DataRD     <= '0;
            TimeoutErr <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            waitCnt    <= waitCntNext;
            MemReq     <= memReqNext;
            MemWE      <= memWENext;
            MemAddr    <= memAddrNext;
            MemWD      <= memWDNext;
            MemBE      <= memBENext;
            InstrValid <= instrValidNext;
            InstrRD    <= instrRDNext;
            DataValid  <= dataValidNext;
            DataRD     <= dataRDNext;
            TimeoutErr <= timeoutErrNext;
        end
    end

    // Stalls release in the Valid cycle so the pipeline advances on the following edge.
    assign StallMemReq   = DataReq & ~DataValid;
    assign StallFetchReq = (InstrReq & ~InstrValid) | StallMemReq;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, handshake timing, timeout and async reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        InstrReq;
    logic [31:0] InstrAddr;
    logic        DataReq;
    logic        DataWE;
    logic [31:0] DataAddr;
    logic [31:0] DataWD;
    logic [3:0]  DataBE;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWD;
    logic [3:0]  MemBE;
    logic        MemReady;
    logic [31:0] MemRD;
    logic        InstrValid;
    logic [31:0] InstrRD;
    logic        DataValid;
    logic [31:0] DataRD;
    logic        StallFetchReq;
    logic        StallMemReq;
    logic        TimeoutErr;

    int testsRun;
    int testsFailed;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .InstrReq     (InstrReq),
        .InstrAddr    (InstrAddr),
        .DataReq      (DataReq),
        .DataWE       (DataWE),
        .DataAddr     (DataAddr),
        .DataWD       (DataWD),
        .DataBE       (DataBE),
        .MemReq       (MemReq),
        .MemWE        (MemWE),
        .MemAddr      (MemAddr),
        .MemWD        (MemWD),
        .MemBE        (MemBE),
        .MemReady     (MemReady),
        .MemRD        (MemRD),
        .InstrValid   (InstrValid),
        .InstrRD      (InstrRD),
        .DataValid    (DataValid),
        .DataRD       (DataRD),
        .StallFetchReq(StallFetchReq),
        .StallMemReq  (StallMemReq),
        .TimeoutErr   (TimeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
        $display("[TB] check %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset     = 1'b0;
        InstrReq  = 1'b0;
        InstrAddr = 32'h0;
        DataReq   = 1'b0;
        DataWE    = 1'b0;
        DataAddr  = 32'h0;
        DataWD    = 32'h0;
        DataBE    = 4'h0;
        MemReady  = 1'b0;
        MemRD     = 32'h0;
        #12;
        check("rst_memreq", {31'd0, MemReq}, 32'd0);
        check("rst_memaddr", MemAddr, 32'h0);
        check("rst_membe", {28'd0, MemBE}, 32'd0);
        check("rst_instrrd", InstrRD, 32'h0);
        check("rst_datard", DataRD, 32'h0);
        check("rst_timeout", {31'd0, TimeoutErr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single fetch with zero-wait memory
        tick();
        InstrReq = 1'b1; InstrAddr = 32'h100; MemReady = 1'b1; MemRD = 32'hDEADBEEF;
        tick();
        check("t1_memreq", {31'd0, MemReq}, 32'd1);
        check("t1_memaddr", MemAddr, 32'h100);
        check("t1_memwe", {31'd0, MemWE}, 32'd0);
        check("t1_membe", {28'd0, MemBE}, 32'hF);
        check("t1_stallf_wait", {31'd0, StallFetchReq}, 32'd1);
        check("t1_ivalid_early", {31'd0, InstrValid}, 32'd0);
        tick();
        check("t1_ivalid", {31'd0, InstrValid}, 32'd1);
        check("t1_instrrd", InstrRD, 32'hDEADBEEF);
        check("t1_memreq_drop", {31'd0, MemReq}, 32'd0);
        check("t1_stallf_rel", {31'd0, StallFetchReq}, 32'd0);
        InstrReq = 1'b0;
        tick();
        check("t1_ivalid_pulse", {31'd0, InstrValid}, 32'd0);

        // Simultaneous requests: data first, dead cycle, then fetch
        InstrReq = 1'b1; InstrAddr = 32'h104;
        DataReq = 1'b1; DataWE = 1'b0; DataAddr = 32'h200; MemRD = 32'hCAFE0001;
        #1;
        check("t2_stallm_req", {31'd0, StallMemReq}, 32'd1);
        tick();
        check("t2_memaddr_data", MemAddr, 32'h200);
        check("t2_memwe", {31'd0, MemWE}, 32'd0);
        check("t2_stallf", {31'd0, StallFetchReq}, 32'd1);
        tick();
        check("t2_dvalid", {31'd0, DataValid}, 32'd1);
        check("t2_datard", DataRD, 32'hCAFE0001);
        check("t2_dead_memreq", {31'd0, MemReq}, 32'd0);
        check("t2_stallm_rel", {31'd0, StallMemReq}, 32'd0);
        check("t2_stallf_hold", {31'd0, StallFetchReq}, 32'd1);
        DataReq = 1'b0; MemRD = 32'hCAFE0002;
        tick();
        check("t2_memreq_instr", {31'd0, MemReq}, 32'd1);
        check("t2_memaddr_instr", MemAddr, 32'h104);
        check("t2_dvalid_pulse", {31'd0, DataValid}, 32'd0);
        check("t2_stallf_instr", {31'd0, StallFetchReq}, 32'd1);
        tick();
        check("t2_ivalid", {31'd0, InstrValid}, 32'd1);
        check("t2_instrrd", InstrRD, 32'hCAFE0002);
        check("t2_stallf_rel", {31'd0, StallFetchReq}, 32'd0);
        InstrReq = 1'b0;
        tick();

        // Store with three wait cycles: request must stay stable, DataRD untouched
        DataReq = 1'b1; DataWE = 1'b1; DataAddr = 32'h40; DataWD = 32'h12345678; DataBE = 4'b0011;
        MemReady = 1'b0; MemRD = 32'hBAD0BAD0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_memreq_%0d", i), {31'd0, MemReq}, 32'd1);
            check($sformatf("t3_memwe_%0d", i), {31'd0, MemWE}, 32'd1);
            check($sformatf("t3_memaddr_%0d", i), MemAddr, 32'h40);
            check($sformatf("t3_memwd_%0d", i), MemWD, 32'h12345678);
            check($sformatf("t3_membe_%0d", i), {28'd0, MemBE}, 32'h3);
            check($sformatf("t3_stallm_%0d", i), {31'd0, StallMemReq}, 32'd1);
        end
        MemReady = 1'b1;
        tick();
        check("t3_dvalid", {31'd0, DataValid}, 32'd1);
        check("t3_datard_kept", DataRD, 32'hCAFE0001);
        check("t3_memreq_drop", {31'd0, MemReq}, 32'd0);
        check("t3_no_timeout", {31'd0, TimeoutErr}, 32'd0);
        DataReq = 1'b0; DataWE = 1'b0;
        tick();

        // Data request arriving during a stalled fetch waits its turn
        InstrReq = 1'b1; InstrAddr = 32'h108; MemReady = 1'b0;
        tick();
        check("t4_memaddr_instr", MemAddr, 32'h108);
        DataReq = 1'b1; DataWE = 1'b0; DataAddr = 32'h300;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            check($sformatf("t4_memaddr_hold_%0d", i), MemAddr, 32'h108);
            check($sformatf("t4_stallm_%0d", i), {31'd0, StallMemReq}, 32'd1);
        end
        MemReady = 1'b1; MemRD = 32'h11110000;
        tick();
        check("t4_ivalid", {31'd0, InstrValid}, 32'd1);
        check("t4_instrrd", InstrRD, 32'h11110000);
        check("t4_stallm_still", {31'd0, StallMemReq}, 32'd1);
        check("t4_stallf_still", {31'd0, StallFetchReq}, 32'd1);
        InstrReq = 1'b0; MemRD = 32'h22220000;
        tick();
        check("t4_memaddr_data", MemAddr, 32'h300);
        tick();
        check("t4_dvalid", {31'd0, DataValid}, 32'd1);
        check("t4_datard", DataRD, 32'h22220000);
        check("t4_timeout_set", {31'd0, TimeoutErr}, 32'd1);
        DataReq = 1'b0;
        tick();
        check("t4_timeout_sticky", {31'd0, TimeoutErr}, 32'd1);

        // Clear the sticky error with reset
        #2 reset = 1'b0;
        #1;
        check("t5_rst_timeout", {31'd0, TimeoutErr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Timeout at exactly four wait cycles, then normal completion
        DataReq = 1'b1; DataWE = 1'b0; DataAddr = 32'h500; MemReady = 1'b0; MemRD = 32'h55555555;
        tick();
        check("t5_memreq", {31'd0, MemReq}, 32'd1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("t5_timeout_w%0d", i), {31'd0, TimeoutErr}, (i >= 4) ? 32'd1 : 32'd0);
        end
        MemReady = 1'b1;
        tick();
        check("t5_dvalid", {31'd0, DataValid}, 32'd1);
        check("t5_datard", DataRD, 32'h55555555);
        check("t5_timeout_kept", {31'd0, TimeoutErr}, 32'd1);
        DataReq = 1'b0;
        tick();

        // Asynchronous reset in the middle of a data transaction
        DataReq = 1'b1; DataWE = 1'b1; DataAddr = 32'h600; DataWD = 32'hA5A5A5A5; DataBE = 4'b1111;
        MemReady = 1'b0;
        tick();
        check("t6_memreq_pre", {31'd0, MemReq}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_memreq", {31'd0, MemReq}, 32'd0);
        check("t6_memwe", {31'd0, MemWE}, 32'd0);
        check("t6_memaddr", MemAddr, 32'h0);
        check("t6_memwd", MemWD, 32'h0);
        check("t6_membe", {28'd0, MemBE}, 32'd0);
        check("t6_datard", DataRD, 32'h0);
        check("t6_timeout", {31'd0, TimeoutErr}, 32'd0);
        DataReq = 1'b0; MemReady = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_no_dvalid_%0d", i), {31'd0, DataValid}, 32'd0);
            check($sformatf("t6_idle_memreq_%0d", i), {31'd0, MemReq}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch (IF) and data access (MEM stage).
- Drives a request/ready handshake on the memory side.
- Returns registered read data to each requester.
- Produces stall requests that the hazard unit ORs into StallF/StallD/StallE/StallM.
- Sits between the fetch/memory-stage logic and the memory interface.

Parameters:
ADDR_WIDTH, 32, address width of all address ports
DATA_WIDTH, 32, data width of all data ports
TIMEOUT, 255, max cycles to wait for MemReady before flagging an error; 8-bit counter, range 1..255

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
InstrReq  input  1  fetch requests a word at InstrAddr
InstrAddr  input  ADDR_WIDTH  fetch address
DataReq  input  1  MEM stage requests an access
DataWE  input  1  1 = store, 0 = load
DataAddr  input  ADDR_WIDTH  data address
DataWD  input  DATA_WIDTH  store data
DataBE  input  4  store byte enables
MemReq  output  1  request to memory
MemWE  output  1  write enable to memory
MemAddr  output  ADDR_WIDTH  memory address
MemWD  output  DATA_WIDTH  memory write data
MemBE  output  4  memory byte enables
MemReady  input  1  memory accepts/completes the current request this cycle
MemRD  input  DATA_WIDTH  memory read data, valid when MemReady=1
InstrValid  output  1  one-cycle pulse: InstrRD holds the fetched word
InstrRD  output  DATA_WIDTH  registered fetch data
DataValid  output  1  one-cycle pulse: data access complete; DataRD valid for loads
DataRD  output  DATA_WIDTH  registered load data
StallFetchReq  output  1  to hazard unit: hold IF/ID
StallMemReq  output  1  to hazard unit: hold whole pipeline up to MEM
TimeoutErr  output  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous) values: state=IDLE, MemReq=0, MemWE=0, MemAddr=0, MemWD=0, MemBE=0, InstrValid=0, InstrRD=0, DataValid=0, DataRD=0, TimeoutErr=0, wait counter=0.
- Reset asserted mid-transaction abandons it immediately; no valid pulse is produced afterwards.
- FSM states are IDLE, INSTR, DATA. All Mem* outputs are registered.
- IDLE:
  - DataReq=1: latch DataAddr/DataWE/DataWD/DataBE into Mem*, set MemReq=1, go to DATA. Data has priority because it belongs to the older instruction.
  - Else InstrReq=1: latch InstrAddr, set MemWE=0, MemBE=4'b1111, MemReq=1, go to INSTR.
  - Else stay in IDLE with MemReq=0.
- INSTR/DATA: MemReq and the latched address/data are held stable until the first cycle with MemReady=1. No preemption. A DataReq that arrives during INSTR waits.
- Completion on the MemReady=1 edge:
  - The registered RD captures MemRD: InstrRD from INSTR, DataRD from DATA on loads only; stores leave DataRD unchanged.
  - The matching Valid pulses high for exactly the next cycle.
  - MemReq drops to 0 and the FSM returns to IDLE.
- Minimum latency: request seen in IDLE at cycle N, MemReq=1 at N+1; with MemReady=1 at N+1, Valid=1 at N+2.
- Back-to-back: the IDLE cycle after completion arbitrates again. One dead cycle with MemReq=0 between transactions is required.
- Stall outputs are combinational:
  - StallMemReq = DataReq & ~DataValid.
  - StallFetchReq = (InstrReq & ~InstrValid) | StallMemReq.
  - A requester keeps its Req high until it sees its Valid.
  - In the Valid cycle the stall is released, so the pipeline advances on that edge. Req may then drop or present a new address.
- Timeout:
  - The wait counter clears on entering INSTR/DATA and increments each cycle MemReady=0.
  - When it reaches TIMEOUT, TimeoutErr is set. It is sticky until reset.
  - The transaction keeps waiting; no abort.
- MemReady=1 in IDLE is ignored. The counter saturates at 255 and does not wrap.

Test Plan:
- Reset, then InstrReq=1 with InstrAddr=0x100 and MemReady tied 1 -> MemReq=1, MemAddr=0x100 one cycle later; InstrValid pulse one cycle after that; InstrRD=MemRD (0xDEADBEEF); StallFetchReq=0 in the Valid cycle.
- InstrReq=1 and DataReq=1 (load 0x200) in the same IDLE cycle -> DATA served first (MemAddr=0x200), then the dead cycle, then INSTR at InstrAddr; StallFetchReq stays 1 until InstrValid.
- Store with DataAddr=0x40, DataWD=0x12345678, DataBE=4'b0011, MemReady delayed 3 cycles -> MemAddr/MemWD/MemBE/MemWE=1 stable for all 4 request cycles; DataValid pulse; DataRD unchanged.
- DataReq arrives while INSTR is waiting (MemReady low 5 cycles) -> no preemption; INSTR completes first, DATA follows; StallMemReq=1 throughout.
- TIMEOUT=4, MemReady held 0 -> TimeoutErr=1 after 4 wait cycles and stays 1; then MemReady=1 -> transaction completes normally.
- Assert reset in DATA with MemReq=1 -> all outputs return to their reset values asynchronously; no DataValid pulse after reset is released.
